// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into fixed-width blinks on an LED pin.
// Rising edges on i are queued, and the queued blinks play back one after another.
module pulse_stretcher #(
  parameter int unsigned      CNT_W      = 24,
  parameter logic [CNT_W-1:0] ON_CYCLES  = 24'd8_000_000,
  parameter logic [CNT_W-1:0] OFF_CYCLES = 24'd4_000_000,
  parameter int unsigned      PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i,
  output logic              o,
  output logic              busy,
  output logic [PEND_W-1:0] pend,
  output logic              ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
  } state_t;

  localparam logic [CNT_W-1:0]  ON_LAST  = ON_CYCLES - 1'b1;
  localparam logic [CNT_W-1:0]  OFF_LAST = OFF_CYCLES - 1'b1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              i_q;
  logic              o_q, o_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              ev;
  logic              queue_ev;

  always_comb begin
    ev       = i & ~i_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    ovf_d    = 1'b0;
    queue_ev = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ev) begin
          state_d = S_ON;
          cnt_d   = '0;
        end
      end
      S_ON: begin
        queue_ev = ev;
        if (cnt_q == ON_LAST) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OFF: begin
        if (cnt_q == OFF_LAST) begin
          cnt_d = '0;
          if (pend_q != '0) begin
            state_d = S_ON;
            // A coinciding event takes the slot freed by the blink now starting.
            if (!ev) pend_d = pend_q - 1'b1;
          end else if (ev) begin
            state_d = S_ON;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d    = cnt_q + 1'b1;
          queue_ev = ev;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (queue_ev) begin
      if (pend_q == PEND_MAX) ovf_d  = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end

    o_d    = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      i_q     <= 1'b1;
      o_q     <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      i_q     <= i;
      o_q     <= o_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o    = o_q;
  assign busy = busy_q;
  assign pend = pend_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: the reference model schedules blink start times from
// the event rules, and the bench compares the DUT outputs against it every cycle.
module tb_pulse_stretcher;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int P    = ON + OFF;
  localparam int PMAX = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i   = 1'b1;
  logic       o, busy, ovf;
  logic [1:0] pend;

  int total = 0;
  int bad   = 0;

  pulse_stretcher #(
    .CNT_W(24),
    .ON_CYCLES(24'd4),
    .OFF_CYCLES(24'd3),
    .PEND_W(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .i   (i),
    .o   (o),
    .busy(busy),
    .pend(pend),
    .ovf (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a list of blink start edges. Blink at s is high over edges
  // s..s+ON-1 and busy over s..s+P-1; queued blinks follow back-to-back.
  longint starts[$];
  longint k       = 0;
  bit     m_prev  = 1'b1;
  bit     armed   = 1'b0;
  bit     m_o     = 1'b0;
  bit     m_busy  = 1'b0;
  bit     m_ovf   = 1'b0;
  int     m_pend  = 0;

  always @(posedge clk) begin
    int q;
    bit ev;
    k++;
    m_ovf = 1'b0;
    while (starts.size() > 0 && starts[0] + P <= k) starts.delete(0);
    if (rst) begin
      starts.delete();
      m_prev = 1'b1;
      armed  = 1'b1;
    end else begin
      ev     = i && !m_prev;
      m_prev = i;
      if (ev) begin
        if (starts.size() == 0 || k >= starts[$] + P) begin
          starts.push_back(k);
        end else begin
          q = 0;
          foreach (starts[j]) if (starts[j] > k) q++;
          if (q < PMAX) starts.push_back(starts[$] + P);
          else          m_ovf = 1'b1;
        end
      end
    end
    m_o    = 1'b0;
    m_busy = 1'b0;
    m_pend = 0;
    foreach (starts[j]) begin
      if (starts[j] <= k && k < starts[j] + ON) m_o = 1'b1;
      if (starts[j] <= k) m_busy = 1'b1;
      if (starts[j] > k) m_pend++;
    end
  end

  int blinks   = 0;
  int ovf_seen = 0;
  bit o_prev   = 1'b0;

  always @(negedge clk) begin
    if (armed) begin
      chk("model_o", int'(o), int'(m_o));
      chk("model_busy", int'(busy), int'(m_busy));
      chk("model_pend", int'(pend), m_pend);
      chk("model_ovf", int'(ovf), int'(m_ovf));
    end
    if (o && !o_prev) blinks++;
    if (ovf) ovf_seen++;
    o_prev = o;
  end

  task automatic tick(input bit iv);
    i   = iv;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_rst(input bit iv);
    i   = iv;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick(1'b0);
      n++;
    end
    chk("idle_wait", int'(busy), 0);
  endtask

  bit pat_o    [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  bit pat_busy [8] = '{1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    // Input held high through reset release: no event, no blink.
    repeat (3) tick_rst(1'b1);
    chk("rst_o", int'(o), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pend", int'(pend), 0);
    chk("rst_ovf", int'(ovf), 0);
    for (int n = 0; n < 20; n++) begin
      tick(1'b1);
      chk("held_o", int'(o), 0);
      chk("held_busy", int'(busy), 0);
    end
    tick(1'b0);
    tick(1'b0);

    // Single event: 4 high, 3 low, busy drops at t+7.
    tick(1'b1);
    for (int n = 0; n < 8; n++) begin
      if (n > 0) tick(1'b0);
      chk("single_o", int'(o), int'(pat_o[n]));
      chk("single_busy", int'(busy), int'(pat_busy[n]));
      chk("single_pend", int'(pend), 0);
    end

    // Queued events: three more pulses while the first blink plays.
    tick(1'b0);
    blinks = 0;
    tick(1'b1);
    tick(1'b0); tick(1'b1); chk("queue_pend1", int'(pend), 1);
    tick(1'b0); tick(1'b1); chk("queue_pend2", int'(pend), 2);
    tick(1'b0); tick(1'b1); chk("queue_pend3", int'(pend), 3);
    tick(1'b0);
    chk("queue_pend_step", int'(pend), 2);
    chk("queue_blink2_o", int'(o), 1);
    wait_idle();
    chk("queue_blinks", blinks, 4);

    // Overflow: 7 pulses two edges apart; drops at the 6th and 7th pulse.
    tick(1'b0);
    blinks   = 0;
    ovf_seen = 0;
    for (int p = 0; p < 7; p++) begin
      tick(1'b1);
      tick(1'b0);
    end
    wait_idle();
    chk("ovf_count", ovf_seen, 2);
    chk("ovf_blinks", blinks, 5);

    // Event in last OFF cycle with nothing pending: immediate restart.
    tick(1'b0);
    tick(1'b1);
    for (int n = 1; n < 7; n++) begin
      tick(1'b0);
      chk("edge0_busy", int'(busy), 1);
    end
    tick(1'b1);
    chk("edge0_o", int'(o), 1);
    chk("edge0_busy_t7", int'(busy), 1);
    chk("edge0_pend", int'(pend), 0);
    tick(1'b0);
    wait_idle();

    // Event in last OFF cycle with pend=2: pend holds at 2.
    tick(1'b0);
    tick(1'b1);
    tick(1'b0); tick(1'b1);
    tick(1'b0); tick(1'b1);
    tick(1'b0); tick(1'b0);
    chk("edge2_pend_before", int'(pend), 2);
    tick(1'b1);
    chk("edge2_pend", int'(pend), 2);
    chk("edge2_o", int'(o), 1);

    // Reset mid-blink discards everything queued.
    tick_rst(1'b0);
    chk("midrst_o", int'(o), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pend", int'(pend), 0);
    blinks = 0;
    for (int n = 0; n < 20; n++) tick(1'b0);
    chk("midrst_blinks", blinks, 0);
    chk("midrst_busy_after", int'(busy), 0);

    // Random traffic with occasional resets, checked by the model.
    for (int n = 0; n < 3000; n++) begin
      i   = ($urandom_range(0, 99) < 30);
      rst = ($urandom_range(0, 499) == 0);
      @(posedge clk);
      #1;
    end
    tick(1'b0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
